// File: rtl/or_pack_loader.sv
// Serial-to-parallel loader: packs NUMBER_INPUT words of BIT bits into one OR-reduction operand bus.
// Optional early frame close via `flush` is built only when OR_PACK_FLUSH_EN is defined.
module or_pack_loader #(
   parameter  int BIT          = 29,
   parameter  int NUMBER_INPUT = 16,
   localparam int CW           = $clog2(NUMBER_INPUT + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [BIT-1:0]              in_data,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUMBER_INPUT*BIT-1:0] OUT,
   output logic [CW-1:0]               count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [NUMBER_INPUT*BIT-1:0] r_out;
   logic [CW-1:0]               r_count;
   logic                        w_out_valid;
   logic                        w_in_ready;
   logic                        w_accept;
   logic                        w_release;
   logic                        w_flush;
   logic                        w_last;

`ifdef OR_PACK_FLUSH_EN
   assign w_flush = flush;
`else
   // Port kept for a uniform interface; folded to zero so frames close only when full.
   assign w_flush = flush & 1'b0;
`endif

   assign w_accept  = in_valid && w_in_ready;
   assign w_release = w_out_valid && out_ready;
   assign w_last    = (r_count == CW'(NUMBER_INPUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: begin
            // Flush with nothing captured yet is ignored, even alongside an accept.
            if (w_accept) w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if ((w_accept && w_last) || w_flush) w_state_nxt = S_FULL;
         end
         S_FULL: begin
            if (out_ready) w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      w_out_valid = (r_state == S_FULL);
      w_in_ready  = (r_state != S_FULL);
   end

   // Lane storage: cleared on release so unwritten lanes are the OR identity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_count <= '0;
      end else if (w_release) begin
         r_out   <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         for (int k = 0; k < NUMBER_INPUT; k++) begin
            if (r_count == CW'(k)) r_out[k*BIT +: BIT] <= in_data;
         end
         r_count <= r_count + CW'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign OUT       = r_out;
   assign count     = r_count;

endmodule

// File: tb/tb_or_pack_loader.sv
// Bench for or_pack_loader: directed and random traffic checked against a queue-based frame model.
module tb_or_pack_loader;

   localparam int BIT = 29;
   localparam int N   = 16;
   localparam int CW  = $clog2(N + 1);
   localparam int W   = N * BIT;
`ifdef OR_PACK_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic [BIT-1:0] in_data;
   logic           in_ready;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   OUT;
   logic [CW-1:0]  count;

   int checks = 0;
   int errors = 0;

   // Reference model: words of the current frame, and whether the frame is on offer.
   logic [BIT-1:0] m_q[$];
   bit             m_full;

   or_pack_loader #(.BIT(BIT), .NUMBER_INPUT(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .OUT      (OUT),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_frame();
      logic [W-1:0] f;
      f = '0;
      for (int k = 0; k < m_q.size(); k++) f[k*BIT +: BIT] = m_q[k];
      return f;
   endfunction

   // One clock: check in_ready before the edge, advance the model, check outputs after it.
   task automatic cycle();
      logic           acc;
      logic           rel;
      logic           fl;
      logic [BIT-1:0] d;
      chk("in_ready", W'(in_ready), W'(!m_full));
      acc = in_valid && !m_full;
      rel = m_full && out_ready;
      fl  = FLUSH_EN && flush && !m_full && (m_q.size() > 0);
      d   = in_data;
      @(posedge clk);
      #1;
      if (rel) begin
         m_q.delete();
         m_full = 1'b0;
      end else begin
         if (acc) m_q.push_back(d);
         if ((m_q.size() == N) || fl) m_full = 1'b1;
      end
      chk("out_valid", W'(out_valid), W'(m_full));
      chk("count", W'(count), W'(m_q.size()));
      chk("OUT", OUT, model_frame());
   endtask

   task automatic send(input logic [BIT-1:0] d, input logic fl);
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      cycle();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int seq;
      logic [W-1:0] onehot;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      m_full    = 1'b0;
      #12;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_count", W'(count), W'(0));
      chk("rst_OUT", OUT, W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back one-hot words, downstream always ready.
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1;
         in_data  = BIT'(1) << k;
         cycle();
      end
      in_valid = 1'b0;
      onehot = '0;
      for (int k = 0; k < N; k++) onehot[k*BIT +: BIT] = BIT'(1) << k;
      chk("onehot_frame", OUT, onehot);
      chk("onehot_count", W'(count), W'(N));
      idle(2);

      // Downstream stalls for 5 cycles while upstream keeps offering words.
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) send(BIT'(32'h00ABC000 + k), 1'b0);
      in_valid = 1'b1;
      in_data  = BIT'(32'h1FFFFFFF);
      idle(5);
      chk("stall_count", W'(count), W'(N));
      out_ready = 1'b1;
      in_valid  = 1'b0;
      idle(2);
      chk("after_release_OUT", OUT, W'(0));

      // 50% valid density, data tagged with its sequence number.
      seq = 0;
      for (int i = 0; i < 80; i++) begin
         in_valid = 1'($urandom % 2);
         in_data  = BIT'(32'h1ABCDEF0 + seq);
         if (in_valid && !m_full) begin
            cycle();
            seq++;
         end else begin
            cycle();
         end
      end
      in_valid = 1'b0;

      // Flush directed: partial frame, flush while empty, flush with an accept.
      idle(3);
      out_ready = 1'b0;
      send(BIT'(5), 1'b0);
      send(BIT'(10), 1'b0);
      send(BIT'(16), 1'b0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      out_ready = 1'b1;
      idle(2);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_empty_no_frame", W'(out_valid), W'(0));
      out_ready = 1'b0;
      send(BIT'(32'h111), 1'b0);
      send(BIT'(32'h222), 1'b0);
      send(BIT'(32'h333), 1'b0);
      send(BIT'(32'h444), 1'b1);
      out_ready = 1'b1;
      idle(3);

      // Mixed random traffic including backpressure and flush.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom % 2);
         in_data   = BIT'($urandom);
         out_ready = (($urandom % 4) != 0);
         flush     = (($urandom % 8) == 0);
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      idle(3);

      // Asynchronous reset in the middle of a frame.
      for (int k = 0; k < 7; k++) send(BIT'(32'h0DEAD00 + k), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_count", W'(count), W'(0));
      chk("midrst_OUT", OUT, W'(0));
      chk("midrst_out_valid", W'(out_valid), W'(0));
      m_q.delete();
      m_full = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(BIT'(32'h0BEEF), 1'b0);
      chk("restart_lane0", W'(OUT[BIT-1:0]), W'(32'h0BEEF));
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
